// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the 6502 external bus between the CPU, a sprite
// (OAM) page-copy engine and a single-byte sample (DMC) fetcher. The core is
// stalled through RDY. Transfers are aligned to get/put cycle parity.
module dma_bus_arbiter (
    input  logic        PHI0,
    input  logic        RES,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    input  logic [7:0]  bus_din,
    output logic        RDY,
    output logic [15:0] ab,
    output logic        bus_rw,
    output logic [7:0]  bus_dout,
    output logic        oam_busy,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data
);

    localparam logic [15:0] OAM_REG  = 16'h4014;
    localparam logic [15:0] OAM_DEST = 16'h2004;

    typedef enum logic [1:0] {IDLE, HALT, DUMMY, XFER} state_t;
    typedef enum logic [2:0] {
        SLOT_PASS, SLOT_DUMMY, SLOT_DMC_GET, SLOT_OAM_GET, SLOT_OAM_PUT, SLOT_ALIGN
    } slot_t;

    state_t      state_q, state_d;
    logic        p_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic        valid_q, valid_d;
    logic        oam_busy_q, oam_busy_d;
    logic        dmc_pend_q, dmc_pend_d;
    logic        dmc_ack_q, dmc_ack_d;
    logic [7:0]  dmc_data_q, dmc_data_d;
    logic        rdy_q, rdy_d;
    slot_t       slot_s;
    logic        trigger_s;

    assign RDY      = rdy_q;
    assign oam_busy = oam_busy_q;
    assign dmc_ack  = dmc_ack_q;
    assign dmc_data = dmc_data_q;

    // Decode what the current cycle does on the bus; DMC wins the GET slot.
    always_comb begin
        slot_s = SLOT_PASS;
        case (state_q)
            IDLE, HALT: slot_s = SLOT_PASS;
            DUMMY:      slot_s = SLOT_DUMMY;
            XFER: begin
                if (!p_q && dmc_pend_q) begin
                    slot_s = SLOT_DMC_GET;
                end else if (!p_q && oam_busy_q) begin
                    slot_s = SLOT_OAM_GET;
                end else if (p_q && valid_q) begin
                    slot_s = SLOT_OAM_PUT;
                end else begin
                    slot_s = SLOT_ALIGN;
                end
            end
            default:    slot_s = SLOT_PASS;
        endcase
    end

    // External bus mux: pass-through unless a DMA slot owns the bus.
    always_comb begin
        ab       = cpu_addr;
        bus_rw   = cpu_rw;
        bus_dout = cpu_dout;
        case (slot_s)
            SLOT_PASS: begin
                ab     = cpu_addr;
                bus_rw = cpu_rw;
            end
            SLOT_DUMMY, SLOT_ALIGN: begin
                ab     = cpu_addr;
                bus_rw = 1'b1;
            end
            SLOT_DMC_GET: begin
                ab     = dmc_addr;
                bus_rw = 1'b1;
            end
            SLOT_OAM_GET: begin
                ab     = {page_q, idx_q};
                bus_rw = 1'b1;
            end
            SLOT_OAM_PUT: begin
                ab       = OAM_DEST;
                bus_rw   = 1'b0;
                bus_dout = latch_q;
            end
            default: begin
                ab     = cpu_addr;
                bus_rw = cpu_rw;
            end
        endcase
    end

    // Next-state: OAM trigger, DMC pending flag, slot side effects, FSM.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        latch_d    = latch_q;
        valid_d    = valid_q;
        oam_busy_d = oam_busy_q;
        dmc_data_d = dmc_data_q;
        dmc_ack_d  = 1'b0;

        trigger_s = ((state_q == IDLE) || (state_q == HALT)) && !cpu_rw &&
                    (cpu_addr == OAM_REG) && !oam_busy_q;

        // The ack cycle is masked so a requester still holding dmc_req
        // while it sees the ack does not cause a second fetch.
        if (slot_s == SLOT_DMC_GET) begin
            dmc_pend_d = 1'b0;
        end else if (dmc_req && !dmc_ack_q) begin
            dmc_pend_d = 1'b1;
        end else begin
            dmc_pend_d = dmc_pend_q;
        end

        if (trigger_s) begin
            page_d     = cpu_dout;
            idx_d      = 8'd0;
            valid_d    = 1'b0;
            oam_busy_d = 1'b1;
        end else if (slot_s == SLOT_DMC_GET) begin
            dmc_data_d = bus_din;
            dmc_ack_d  = 1'b1;
        end else if (slot_s == SLOT_OAM_GET) begin
            latch_d = bus_din;
            valid_d = 1'b1;
        end else if (slot_s == SLOT_OAM_PUT) begin
            valid_d = 1'b0;
            idx_d   = idx_q + 8'd1;
            if (idx_q == 8'd255) begin
                oam_busy_d = 1'b0;
            end else begin
                oam_busy_d = oam_busy_q;
            end
        end else begin
            latch_d = latch_q;
        end

        case (state_q)
            IDLE: begin
                if (trigger_s || dmc_pend_q) begin
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                // Core writes ignore RDY, so only a read cycle ends the halt.
                if (cpu_rw) begin
                    if (dmc_pend_q && !oam_busy_q) begin
                        state_d = DUMMY;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = HALT;
                end
            end
            DUMMY:   state_d = XFER;
            XFER: begin
                if (!oam_busy_d && !dmc_pend_d) begin
                    state_d = IDLE;
                end else begin
                    state_d = XFER;
                end
            end
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == IDLE);
    end

    // State and registered outputs; synchronous reset; parity toggles each cycle.
    always_ff @(posedge PHI0) begin
        if (RES) begin
            state_q    <= IDLE;
            p_q        <= 1'b0;
            page_q     <= 8'd0;
            idx_q      <= 8'd0;
            latch_q    <= 8'd0;
            valid_q    <= 1'b0;
            oam_busy_q <= 1'b0;
            dmc_pend_q <= 1'b0;
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'd0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            p_q        <= ~p_q;
            page_q     <= page_d;
            idx_q      <= idx_d;
            latch_q    <= latch_d;
            valid_q    <= valid_d;
            oam_busy_q <= oam_busy_d;
            dmc_pend_q <= dmc_pend_d;
            dmc_ack_q  <= dmc_ack_d;
            dmc_data_q <= dmc_data_d;
            rdy_q      <= rdy_d;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter. A bus model returns data derived from
// the address; expected DMA reads, OAM writes and DMC bytes are queued when
// stimulus is issued and compared when the DUT puts them on the bus.
module tb_dma_bus_arbiter;

    logic        PHI0;
    logic        RES;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic [7:0]  bus_din;
    logic        RDY;
    logic [15:0] ab;
    logic        bus_rw;
    logic [7:0]  bus_dout;
    logic        oam_busy;
    logic        dmc_ack;
    logic [7:0]  dmc_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int ack_cnt = 0;
    int dmc_gets = 0;
    logic mon_en = 1'b1;

    logic [15:0] exp_get[$];
    logic [7:0]  exp_put[$];
    logic [7:0]  exp_dmc[$];
    logic [15:0] mon_ea;
    logic [7:0]  mon_ed;

    function automatic logic [7:0] bus_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign bus_din = bus_f(ab);

    dma_bus_arbiter dut (
        .PHI0(PHI0), .RES(RES), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_rw(cpu_rw), .dmc_req(dmc_req), .dmc_addr(dmc_addr), .bus_din(bus_din),
        .RDY(RDY), .ab(ab), .bus_rw(bus_rw), .bus_dout(bus_dout),
        .oam_busy(oam_busy), .dmc_ack(dmc_ack), .dmc_data(dmc_data)
    );

    initial PHI0 = 1'b0;
    always #5 PHI0 = ~PHI0;

    // Cycle index since reset release; its LSB is the get/put parity.
    always @(posedge PHI0) begin
        if (RES) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop expectations as DMA traffic appears on the bus.
    always @(negedge PHI0) begin
        if (!RES) begin
            if (!RDY) stall_cnt++;
            if (mon_en && !RDY && (ab !== cpu_addr)) begin
                if (bus_rw) begin
                    if (ab[15:12] == 4'hC) begin
                        dmc_gets++;
                    end else begin
                        chk("get_expected", 32'(exp_get.size() > 0), 32'd1);
                        if (exp_get.size() > 0) begin
                            mon_ea = exp_get.pop_front();
                            chk("get_addr", 32'(ab), 32'(mon_ea));
                        end
                    end
                end else begin
                    chk("put_addr", 32'(ab), 32'h2004);
                    chk("put_expected", 32'(exp_put.size() > 0), 32'd1);
                    if (exp_put.size() > 0) begin
                        mon_ed = exp_put.pop_front();
                        chk("put_data", 32'(bus_dout), 32'(mon_ed));
                    end
                end
            end
            if (mon_en && dmc_ack) begin
                ack_cnt++;
                chk("dmc_expected", 32'(exp_dmc.size() > 0), 32'd1);
                if (exp_dmc.size() > 0) begin
                    mon_ed = exp_dmc.pop_front();
                    chk("dmc_data", 32'(dmc_data), 32'(mon_ed));
                end
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(posedge PHI0);
        #1;
        cpu_addr = a;
        cpu_dout = d;
        cpu_rw   = rw;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'h8000, 8'h00, 1'b1);
    endtask

    // Wait for a stall to begin, then for RDY to return; drop dmc_req on ack.
    task automatic wait_idle(input string tag);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge PHI0);
            if (dmc_ack === 1'b1) dmc_req = 1'b0;
            if (RDY === 1'b0 || n >= 8) done = 1'b1;
            else n++;
        end
        chk({tag, "_start_timeout"}, 32'(n < 8), 32'd1);
        n = 0;
        done = 1'b0;
        while (!done) begin
            if (dmc_ack === 1'b1) dmc_req = 1'b0;
            if (RDY === 1'b1 || n >= 1000) done = 1'b1;
            else begin
                n++;
                @(negedge PHI0);
            end
        end
        chk({tag, "_end_timeout"}, 32'(n < 1000), 32'd1);
    endtask

    // Issue a $4014 write (trigger cycle parity par) with optional extra
    // core writes and a duplicate trigger during HALT, then a read.
    task automatic start_oam(input logic [7:0] page, input logic par, input int n_wr,
                             input logic dup, output logic tpar);
        logic [15:0] a;
        for (int i = 0; i < 256; i++) begin
            a = {page, 8'(i)};
            exp_get.push_back(a);
            exp_put.push_back(bus_f(a));
        end
        if (cyc[0] == par) idle(1);
        stall_cnt = 0;
        drive(16'h4014, page, 1'b0);
        tpar = cyc[0];
        @(negedge PHI0);
        chk("trig_rdy", 32'(RDY), 32'd1);
        for (int j = 0; j < n_wr; j++) begin
            a = 16'h01FD - 16'(j);
            drive(a, 8'hA0 + 8'(j), 1'b0);
            @(negedge PHI0);
            chk("halt_wr_rdy", 32'(RDY), 32'd0);
            chk("halt_wr_ab", 32'(ab), 32'(a));
            chk("halt_wr_rw", 32'(bus_rw), 32'd0);
            chk("halt_wr_dout", 32'(bus_dout), 32'(8'hA0 + 8'(j)));
        end
        if (dup) begin
            drive(16'h4014, page + 8'd1, 1'b0);
            @(negedge PHI0);
            chk("dup_rdy", 32'(RDY), 32'd0);
            chk("dup_ab", 32'(ab), 32'h4014);
        end
        drive(16'h8000, 8'h00, 1'b1);
        @(negedge PHI0);
        chk("halt_rdy", 32'(RDY), 32'd0);
        chk("halt_busy", 32'(oam_busy), 32'd1);
    endtask

    task automatic dmc_run(input logic par, input logic [15:0] a, output int s);
        if (cyc[0] != par) idle(1);
        ack_cnt = 0;
        dmc_gets = 0;
        stall_cnt = 0;
        exp_dmc.push_back(bus_f(a));
        drive(16'h8000, 8'h00, 1'b1);
        dmc_addr = a;
        dmc_req = 1'b1;
        wait_idle("dmc");
        s = stall_cnt;
        chk("dmc_stall_range", 32'((s == 3) || (s == 4)), 32'd1);
        idle(3);
        @(negedge PHI0);
        chk("dmc_ack_once", 32'(ack_cnt), 32'd1);
        chk("dmc_get_once", 32'(dmc_gets), 32'd1);
        chk("dmc_ack_low", 32'(dmc_ack), 32'd0);
        chk("dmc_data_hold", 32'(dmc_data), 32'(bus_f(a)));
    endtask

    task automatic oam_done(input string tag, input int exp_stall);
        wait_idle(tag);
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_busy_clr"}, 32'(oam_busy), 32'd0);
        chk({tag, "_gets_left"}, 32'(exp_get.size()), 32'd0);
        chk({tag, "_puts_left"}, 32'(exp_put.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tp;
        int s0, s1;
        RES = 1'b1;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        cpu_rw = 1'b1;
        dmc_req = 1'b0;
        dmc_addr = 16'hC000;
        repeat (3) @(posedge PHI0);
        #1;
        cpu_addr = 16'h1234;
        cpu_dout = 8'h55;
        cpu_rw = 1'b0;
        @(negedge PHI0);
        chk("rst_rdy", 32'(RDY), 32'd1);
        chk("rst_busy", 32'(oam_busy), 32'd0);
        chk("rst_ack", 32'(dmc_ack), 32'd0);
        chk("rst_dmc_data", 32'(dmc_data), 32'd0);
        chk("rst_ab", 32'(ab), 32'h1234);
        chk("rst_rw", 32'(bus_rw), 32'd0);
        chk("rst_dout", 32'(bus_dout), 32'h55);
        @(posedge PHI0);
        #1;
        RES = 1'b0;
        cpu_addr = 16'h8000;
        cpu_rw = 1'b1;
        idle(2);

        // Standalone DMC at both parities: one run takes 3, the other 4.
        dmc_run(1'b0, 16'hC000, s0);
        dmc_run(1'b1, 16'hC011, s1);
        chk("dmc_parity_sum", 32'(s0 + s1), 32'd7);

        // OAM entering XFER on a GET slot, then on a PUT slot.
        start_oam(8'h02, 1'b0, 0, 1'b0, tp);
        oam_done("oam_even", 513 + int'(tp));
        idle(2);
        start_oam(8'h03, 1'b1, 0, 1'b0, tp);
        oam_done("oam_odd", 513 + int'(tp));
        idle(2);

        // Two core writes stretch HALT to 3 cycles.
        start_oam(8'h04, 1'b0, 2, 1'b0, tp);
        oam_done("oam_jsr", 3 + 512 + int'(tp));
        idle(2);

        // A second $4014 write during HALT is ignored (page stays 06).
        start_oam(8'h06, 1'b0, 0, 1'b1, tp);
        oam_done("oam_dup", 2 + 512 + int'(!tp));
        idle(2);

        // DMC request at idx 0x80 steals one GET slot plus an ALIGN.
        start_oam(8'h05, 1'b0, 0, 1'b0, tp);
        idle(257);
        ack_cnt = 0;
        dmc_gets = 0;
        exp_dmc.push_back(bus_f(16'hC080));
        dmc_addr = 16'hC080;
        dmc_req = 1'b1;
        oam_done("oam_dmc", 515 + int'(tp));
        idle(2);
        @(negedge PHI0);
        chk("oam_dmc_ack", 32'(ack_cnt), 32'd1);
        chk("oam_dmc_get", 32'(dmc_gets), 32'd1);

        // Reset mid-OAM at idx 40.
        start_oam(8'h07, 1'b0, 0, 1'b0, tp);
        mon_en = 1'b0;
        idle(81);
        RES = 1'b1;
        idle(3);
        RES = 1'b0;
        @(negedge PHI0);
        chk("res_mid_rdy", 32'(RDY), 32'd1);
        chk("res_mid_busy", 32'(oam_busy), 32'd0);
        chk("res_mid_ab", 32'(ab), 32'(cpu_addr));
        chk("res_mid_ack", 32'(dmc_ack), 32'd0);
        chk("res_mid_dmc_data", 32'(dmc_data), 32'd0);
        exp_get.delete();
        exp_put.delete();
        stall_cnt = 0;
        mon_en = 1'b1;
        idle(30);
        @(negedge PHI0);
        chk("res_mid_no_stall", 32'(stall_cnt), 32'd0);
        chk("res_mid_busy_after", 32'(oam_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
